mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction and data caches; consumes their miss, fill and write-back requests.
- Serialises those requests onto the single-ported RAM interface.
- A grant FSM holds one requester on the RAM until its word access completes.
- Data side has fixed priority, bounded by a starvation counter that guarantees the instruction side progress.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : serialises icache/dcache word requests onto one RAM port
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  localparam int         CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic d_req;
  logic access;
  logic starve_full;

  assign d_req       = dREN | dWEN;
  assign access      = (ramstate == RAM_ACCESS);
  assign starve_full = (starve_cnt == CNT_W'(STARVE_LIMIT));

  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ram_err    <= 1'b0;
    end else begin
      if (ramstate == RAM_ERROR)
        ram_err <= 1'b1;
      unique case (state)
        IDLE: begin
          if (d_req && !(iREN && starve_full))
            state <= DGRANT;
          else if (iREN)
            state <= IGRANT;
        end
        DGRANT: begin
          // A dropped request aborts without touching the starvation count
          if (!d_req) begin
            state <= IDLE;
          end else if (access) begin
            state <= IDLE;
            if (iREN) begin
              if (!starve_full)
                starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        IGRANT: begin
          if (!iREN) begin
            state <= IDLE;
          end else if (access) begin
            state      <= IDLE;
            starve_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM controls follow the live request so an abort or reset drops them at once
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    unique case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~(d_req & access);
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~(iREN & access);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : scoreboard bench for mem_arbiter
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, ram_err;
  logic [1:0]  ramstate;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          side;   // 0 = data, 1 = instruction
    logic [31:0] load;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Completion monitor
  always @(negedge CLK) begin
    if (nRST && (!iwait || !dwait)) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_completion: iwait=%0b dwait=%0b expected none", iwait, dwait);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("cmp_side", {63'd0, !iwait}, {63'd0, e.side});
        chk("cmp_single", {63'd0, iwait | dwait}, 64'd1);
        chk("cmp_load", e.side ? iload : dload, e.load);
        chk("cmp_addr", ramaddr, e.addr);
      end
    end
  end

  // One request, granted after one IDLE cycle; nhold grant cycles of 'hold' precede ACCESS
  task automatic access(input bit side, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rload, input int nhold, input logic [1:0] hold);
    q.push_back('{side, rload, addr});
    ramload  = rload;
    ramstate = FREE;
    if (side) begin
      iREN = 1'b1; iaddr = addr;
    end else begin
      dREN = ren; dWEN = wen; daddr = addr; dstore = data;
    end
    for (int k = 1; k <= nhold + 1; k++) begin
      @(posedge CLK); #1;
      ramstate = (k <= nhold) ? hold : ACC;
      #1;
      chk("grant_addr", ramaddr, addr);
      chk("own_wait", {63'd0, side ? iwait : dwait}, {63'd0, k <= nhold});
      chk("other_wait", {63'd0, side ? dwait : iwait}, 64'd1);
      if (side) begin
        chk("i_ren", {63'd0, ramREN}, 64'd1);
        chk("i_wen", {63'd0, ramWEN}, 64'd0);
        chk("i_store", ramstore, 64'd0);
      end else begin
        chk("d_wen", {63'd0, ramWEN}, {63'd0, wen});
        chk("d_ren", {63'd0, ramREN}, {63'd0, ren & ~wen});
        chk("d_store", ramstore, data);
      end
    end
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    #1;
    chk("idle_ren", {63'd0, ramREN}, 64'd0);
    chk("idle_wen", {63'd0, ramWEN}, 64'd0);
    chk("idle_waits", {62'd0, iwait, dwait}, 64'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
    #12;
    chk("rst_iwait", {63'd0, iwait}, 64'd1);
    chk("rst_dwait", {63'd0, dwait}, 64'd1);
    chk("rst_ren", {63'd0, ramREN}, 64'd0);
    chk("rst_wen", {63'd0, ramWEN}, 64'd0);
    chk("rst_addr", ramaddr, 64'd0);
    chk("rst_store", ramstore, 64'd0);
    chk("rst_err", {63'd0, ram_err}, 64'd0);
    @(posedge CLK); #2;
    nRST = 1'b1;

    access(0, 1, 0, 32'h40, 32'h0, 32'h1111_2222, 0, FREE);
    access(0, 1, 1, 32'h44, 32'hCAFE_F00D, 32'h55, 0, FREE);
    access(1, 1, 0, 32'h80, 32'h0, 32'h3333_4444, 3, BUSY);
    access(0, 1, 0, 32'h48, 32'h0, 32'h66, 1, ERR);
    chk("err_set", {63'd0, ram_err}, 64'd1);
    access(1, 1, 0, 32'h84, 32'h0, 32'h77, 0, FREE);
    chk("err_sticky", {63'd0, ram_err}, 64'd1);

    // Both sides requesting: four data grants, then one instruction grant
    ramload = 32'hABCD_0000; iaddr = 32'h100; daddr = 32'h200; dstore = 32'h0;
    for (int n = 0; n < 6; n++)
      q.push_back('{(n == 4), 32'hABCD_0000, (n == 4) ? 32'h100 : 32'h200});
    iREN = 1'b1; dREN = 1'b1; ramstate = ACC;
    for (int c = 1; c <= 11; c++) begin
      @(posedge CLK); #2;
      if (c == 8)  chk("starve_full", dut.starve_cnt, 64'd4);
      if (c == 10) chk("starve_clear", dut.starve_cnt, 64'd0);
    end
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    #1;
    chk("starve_after", dut.starve_cnt, 64'd1);

    // Abort mid-grant
    dREN = 1'b1; daddr = 32'h90; ramstate = BUSY;
    @(posedge CLK); #2;
    chk("abort_pre_ren", {63'd0, ramREN}, 64'd1);
    dREN = 1'b0; #1;
    chk("abort_ren", {63'd0, ramREN}, 64'd0);
    chk("abort_dwait", {63'd0, dwait}, 64'd1);
    @(posedge CLK); #2;
    chk("abort_state", {62'd0, dut.state}, 64'd0);
    chk("abort_cnt", dut.starve_cnt, 64'd1);

    // Asynchronous reset during a write grant
    dWEN = 1'b1; daddr = 32'hA0; dstore = 32'h77; ramstate = BUSY;
    @(posedge CLK); #2;
    chk("rstg_pre_wen", {63'd0, ramWEN}, 64'd1);
    nRST = 1'b0; #1;
    chk("rstg_wen", {63'd0, ramWEN}, 64'd0);
    chk("rstg_waits", {62'd0, iwait, dwait}, 64'd3);
    chk("rstg_err", {63'd0, ram_err}, 64'd0);
    chk("rstg_state", {62'd0, dut.state}, 64'd0);
    chk("rstg_cnt", dut.starve_cnt, 64'd0);
    dWEN = 1'b0; ramstate = FREE;
    #3 nRST = 1'b1;
    @(posedge CLK); #2;
    access(0, 1, 0, 32'h50, 32'h0, 32'h9999_0001, 0, FREE);

    chk("queue_empty", q.size(), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
